// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: round-robin pick between two byte requesters,
// then one start/data/stop frame per byte, paced by the baud strobe.
module uart_tx_scheduler #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_clk,
    output logic                 baud_rst,
    input  logic                 req0_valid,
    input  logic [DATA_BITS-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_BITS-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 owner,
    output logic                 frame_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic                 prio;
    logic                 any_req;
    logic                 grant;
    logic                 idle;

    // On a tie the requester not served last wins.
    always_comb begin
        any_req = req0_valid | req1_valid;
        grant   = (req0_valid & req1_valid) ? ~prio : req1_valid;
        idle    = (state == IDLE);
    end

    assign req0_ready = reset & idle & req0_valid & ~grant;
    assign req1_ready = reset & idle & req1_valid & grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            prio       <= 1'b1;
            tx         <= 1'b1;
            busy       <= 1'b0;
            baud_rst   <= 1'b1;
            owner      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        shift    <= grant ? req1_data : req0_data;
                        tx       <= 1'b0;
                        baud_rst <= 1'b0;
                        owner    <= grant;
                        prio     <= grant;
                        bit_idx  <= '0;
                        stop_cnt <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_clk) begin
                        tx    <= shift[0];
                        shift <= shift >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (baud_clk) begin
                        if (bit_idx == LAST_IDX) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end
                STOP: begin
                    if (baud_clk) begin
                        if (stop_cnt == LAST_STOP) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            baud_rst   <= 1'b1;
                            frame_done <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Transmit-side controller for the UART: arbitrates between two byte requesters with round-robin priority and sequences one 8N1-style serial frame per accepted byte. It gates the baud generator through its synchronous active-high reset so that every frame starts on a fresh, full-length bit period. It consumes the generator's single-cycle `baud_clk` strobe and drives the serial line directly.

## Interface
- `DATA_BITS`, 8, data bits per frame, LSB first, legal 5..8
- `STOP_BITS`, 1, stop bits per frame, legal 1 or 2
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `baud_clk`  in  1  one-cycle strobe per bit period, from the baud generator
- `baud_rst`  out  1  active-high synchronous reset to the baud generator; holds it cleared while idle
- `req0_valid`  in  1  requester 0 has a byte
- `req0_data`  in  DATA_BITS  requester 0 byte, held stable while `req0_valid`
- `req0_ready`  out  1  requester 0 byte accepted this cycle
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1
- `tx`  out  1  serial line, idle high
- `busy`  out  1  frame in progress
- `owner`  out  1  requester index of the current or most recent frame
- `frame_done`  out  1  one-cycle pulse when the last stop bit ends

## Operation
- States: IDLE, START, DATA, STOP. `busy` = state != IDLE, registered.
- Arbitration, combinational, in IDLE only:
  - If only one valid is high, that requester is granted.
  - If both are high, the requester not equal to `prio` is granted.
  - `prio` holds the last-served index and resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` = IDLE && granted N. A transfer occurs when valid && ready at a posedge.
  - Outside IDLE, both readies are 0.
- Accept edge, IDLE->START:
  - Latch the data into the shift register.
  - `tx`<=0, `baud_rst`<=0, `owner`<=granted index, `prio`<=granted index.
  - Clear the bit index and the stop counter.
- START: on `baud_clk`, `tx`<=shift[0], shift right, go to DATA.
- DATA: on `baud_clk`:
  - If bit index == DATA_BITS-1: `tx`<=1, go to STOP.
  - Otherwise increment the bit index, `tx`<=next shift[0], shift right.
- STOP: on `baud_clk`:
  - If stop count == STOP_BITS-1: go to IDLE, `baud_rst`<=1, `frame_done`<=1.
  - Otherwise increment the stop count.
- The bit index is $clog2(DATA_BITS) bits wide and never exceeds DATA_BITS-1. The stop counter is 1 bit.
- `baud_clk` is ignored in IDLE. A strobe on the accept edge itself is ignored (generator still held in reset).
- Valid deasserting without ready is permitted (no-op). Data changes while not transferred are ignored.

## Timing
- Reset values, applied asynchronously on `reset`=0:
  - State IDLE; `tx`=1, `busy`=0, `baud_rst`=1, `frame_done`=0, `owner`=0, `prio`=1.
  - Shift register, bit index and stop counter all 0.
  - Readies follow the combinational rule, so they are 0 during reset.
- With generator divisor N, release at the accept edge T gives the first strobe in cycle T+N. Every bit lasts exactly N cycles.
- Frame length: (1+DATA_BITS+STOP_BITS)*N cycles from `tx` falling to the `frame_done` edge.
- `frame_done` and the return to IDLE share an edge. The next accept can occur on the following edge, so back-to-back frames have one idle-high cycle of gap.
- Reset mid-frame:
  - `tx` goes high immediately and `baud_rst` goes to 1.
  - The frame is abandoned with no `frame_done` pulse.
  - `prio` returns to 1.
- On the accept edge, `baud_rst` falls and `tx` falls on the same edge.

## Test plan
- Single byte, N=8, DATA_BITS=8, STOP_BITS=1: req0 sends 0xA5 -> `tx` reads 0,1,0,1,0,0,1,0,1,1 (start bit, LSB-first data, stop bit), 8 cycles each. `frame_done` fires 80 cycles after the accept; `owner`=0.
- Simultaneous requests, both valid continuously with req0=0x11 and req1=0x22 -> frames go out in the order 0x11, 0x22, 0x11, with one idle cycle between frames. Each ready pulses exactly once per frame.
- Fairness: req1 valid alone, then both valid -> req1 is served first, then req0 wins the tie.
- STOP_BITS=2, DATA_BITS=5: send 0x1F -> frame is 8*N cycles with two high stop bits. `busy` is high for exactly 8*N cycles.
- Reset mid-DATA bit 3 -> in the same cycle `tx`=1, `busy`=0, `baud_rst`=1, and no `frame_done`. After release, a new req0 byte transmits correctly.
- Spurious `baud_clk` in IDLE and on the accept edge -> no state change, and the start bit still lasts N cycles.
